fornogame: RTL and testbench

- Oven-timing minigame. It sits downstream of the BitBakery top-level controller, in parallel with the other minigames, and its outputs feed the top-level output mux.
- A lit LED pointer sweeps across the 7 button LEDs. The player presses any button when the pointer reaches the target LED, which is the "oven ready" position.
- Each round is scored as a hit or a miss. After ROUNDS rounds the block raises pronto and holds the final score.
- It uses the same game interface as the other minigames (jogar, dificuldade, botoes, estado, jogadas, pontuacao, pronto).

---
 rtl/fornogame_pkg.sv | 36 +++
 rtl/lfsr7_sorteio.sv | 27 ++
 rtl/fornogame.sv | 189 ++++++++++++++++++
 tb/tb_fornogame.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fornogame_pkg.sv
// Shared definitions for the oven-timing minigame (fornogame).
// - state_t  : FSM state codes, also driven on estado for the display/output mux
// - LFSR_SEED: power-on value of the target-drawing LFSR
// - LED_ALL_ON / LED_ALL_OFF: feedback LED patterns
// - mod7()   : 7-bit value modulo 7 without a divider
package fornogame_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        PREPARA = 4'd1,
        SORTEIA = 4'd2,
        VARRE   = 4'd3,
        AVALIA  = 4'd4,
        ACERTO  = 4'd5,
        ERRO    = 4'd6,
        PROXIMA = 4'd7,
        FIM     = 4'd8
    } state_t;

    localparam logic [6:0] LFSR_SEED   = 7'h5A;
    localparam logic [6:0] LED_ALL_ON  = 7'h7F;
    localparam logic [6:0] LED_ALL_OFF = 7'h00;

    // 8 == 1 (mod 7), so summing the octal digits preserves the residue.
    // Two folds bring the sum to 0..8; one conditional subtract finishes it.
    function automatic logic [2:0] mod7(input logic [6:0] v);
        logic [3:0] s1;
        logic [3:0] s2;
        s1 = {3'b000, v[6]} + {1'b0, v[5:3]} + {1'b0, v[2:0]};
        s2 = {3'b000, s1[3]} + {1'b0, s1[2:0]};
        if (s2 >= 4'd7)
            s2 = s2 - 4'd7;
        return 3'(s2);
    endfunction

endpackage

// File: rtl/lfsr7_sorteio.sv
// 7-bit Fibonacci LFSR used to draw the target LED.
// Ports:
//   clock, reset (async, active-high) -- reset loads LFSR_SEED
//   advance     -- step the LFSR once this cycle
//   value_mod7  -- current LFSR value modulo 7 (0..6), i.e. a LED index
module lfsr7_sorteio
    import fornogame_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       advance,
    output logic [2:0] value_mod7
);

    logic [6:0] lfsr;

    // Only reset reseeds; a new game continues the sequence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else if (advance)
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    assign value_mod7 = mod7(lfsr);

endmodule

// File: rtl/fornogame.sv
// Oven-timing minigame: a pointer sweeps the 7 button LEDs, the player
// presses any button when it reaches the target LED. ROUNDS rounds are
// scored, then pronto is raised and the score held.
// Ports:
//   clock, reset    -- game clock, async active-high reset
//   jogar           -- one-cycle start pulse (honoured in IDLE and FIM only)
//   dificuldade     -- 0 easy / 1 hard, sampled with the start pulse
//   botoes[6:0]     -- button levels, active-high
//   estado[3:0]     -- FSM state code
//   jogadas[6:0]    -- LED pattern
//   pontuacao[2:0]  -- hit count (saturates at 7)
//   pronto          -- high while in FIM
module fornogame
    import fornogame_pkg::*;
#(
    parameter int ROUNDS    = 5,
    parameter int STEP_EASY = 500,
    parameter int STEP_HARD = 250,
    parameter int FEEDBACK  = 1000,
    parameter int SWEEPS    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       dificuldade,
    input  logic [6:0] botoes,
    output logic [3:0] estado,
    output logic [6:0] jogadas,
    output logic [2:0] pontuacao,
    output logic       pronto
);

    localparam int STEP_MAX = (STEP_EASY > STEP_HARD) ? STEP_EASY : STEP_HARD;
    localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
    localparam int FB_W     = (FEEDBACK > 1) ? $clog2(FEEDBACK) : 1;
    localparam int SWEEP_W  = $clog2(SWEEPS + 1);

    state_t state, state_nxt;

    logic [6:0]         botoes_q;
    logic               press;
    logic               hard;
    logic [2:0]         pointer;
    logic [2:0]         target;
    logic [2:0]         target_draw;
    logic [2:0]         round;
    logic [STEP_W-1:0]  step_cnt;
    logic [STEP_W-1:0]  step_last;
    logic [SWEEP_W-1:0] sweep_cnt;
    logic [FB_W-1:0]    fb_cnt;
    logic               step_done;
    logic               wrap;
    logic               timeout;
    logic               fb_done;
    logic               hit;
    logic               round_last;
    logic [3:0]         p4;
    logic [3:0]         t4;

    lfsr7_sorteio u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .advance    (state == SORTEIA),
        .value_mod7 (target_draw)
    );

    // Rising edge on any button; simultaneous edges collapse to one press.
    assign press      = |(botoes & ~botoes_q);

    assign step_last  = hard ? STEP_W'(STEP_HARD - 1) : STEP_W'(STEP_EASY - 1);
    assign step_done  = (step_cnt == step_last);
    assign wrap       = step_done && (pointer == 3'd6);
    assign timeout    = wrap && (sweep_cnt == SWEEP_W'(SWEEPS - 1));
    assign fb_done    = (fb_cnt == FB_W'(FEEDBACK - 1));
    assign round_last = (({1'b0, round} + 4'd1) == 4'(ROUNDS));

    // The pointer is frozen on the press cycle, so in AVALIA it still holds
    // the pre-step value that was showing when the button went down.
    assign p4  = {1'b0, pointer};
    assign t4  = {1'b0, target};
    assign hit = hard ? (pointer == target)
                      : ((p4 <= t4 + 4'd1) && (t4 <= p4 + 4'd1));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (jogar) state_nxt = PREPARA;
            PREPARA: state_nxt = SORTEIA;
            SORTEIA: state_nxt = VARRE;
            VARRE: begin
                // A press on the final wrap cycle takes priority over timeout.
                if (press)
                    state_nxt = AVALIA;
                else if (timeout)
                    state_nxt = ERRO;
            end
            AVALIA:  state_nxt = hit ? ACERTO : ERRO;
            ACERTO,
            ERRO:    if (fb_done) state_nxt = PROXIMA;
            PROXIMA: state_nxt = round_last ? FIM : SORTEIA;
            FIM:     if (jogar) state_nxt = PREPARA;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        jogadas = LED_ALL_OFF;
        pronto  = 1'b0;
        case (state)
            VARRE:   jogadas = (7'b1 << pointer) | (7'b1 << target);
            ACERTO:  jogadas = LED_ALL_ON;
            FIM:     pronto  = 1'b1;
            default: ;
        endcase
    end

    assign estado = state;

    // Datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            botoes_q  <= '0;
            hard      <= 1'b0;
            pointer   <= '0;
            target    <= '0;
            round     <= '0;
            step_cnt  <= '0;
            sweep_cnt <= '0;
            fb_cnt    <= '0;
            pontuacao <= '0;
        end else begin
            botoes_q <= botoes;

            if (state == ACERTO || state == ERRO)
                fb_cnt <= fb_cnt + 1'b1;
            else
                fb_cnt <= '0;

            case (state)
                IDLE, FIM: begin
                    // Cleared on the start pulse so PREPARA already shows a zero score.
                    if (jogar) begin
                        hard      <= dificuldade;
                        pontuacao <= '0;
                        round     <= '0;
                    end
                end
                SORTEIA: begin
                    target    <= target_draw;
                    pointer   <= '0;
                    step_cnt  <= '0;
                    sweep_cnt <= '0;
                end
                VARRE: begin
                    if (!press) begin
                        if (step_done) begin
                            step_cnt <= '0;
                            if (pointer == 3'd6) begin
                                pointer   <= '0;
                                sweep_cnt <= sweep_cnt + 1'b1;
                            end else begin
                                pointer <= pointer + 3'd1;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                AVALIA: begin
                    if (hit && pontuacao != 3'd7)
                        pontuacao <= pontuacao + 3'd1;
                end
                PROXIMA: round <= round + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fornogame.sv
// Scoreboard bench for fornogame. Stimulus pushes the expected round outcome
// (state, score, LEDs, pronto) when it presses or lets a round time out; the
// monitor pops and compares each time the DUT enters ACERTO, ERRO or FIM.
// Targets come from a hand-derived LFSR sequence: 6,4,2,2,3,0,6,6,3,5,4,6,3,4,0,1.
module tb_fornogame;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic       dificuldade;
    logic [6:0] botoes;
    logic [3:0] estado;
    logic [6:0] jogadas;
    logic [2:0] pontuacao;
    logic       pronto;

    int n_checks = 0;
    int n_pass   = 0;

    typedef logic [14:0] ev_t;   // {state, pontuacao, jogadas, pronto}
    ev_t sb[$];
    logic [3:0] prev_st = 4'd0;

    always #5 clock = ~clock;

    fornogame #(
        .ROUNDS(5), .STEP_EASY(4), .STEP_HARD(2), .FEEDBACK(3), .SWEEPS(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .jogar       (jogar),
        .dificuldade (dificuldade),
        .botoes      (botoes),
        .estado      (estado),
        .jogadas     (jogadas),
        .pontuacao   (pontuacao),
        .pronto      (pronto)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare on every entry into a result state.
    always @(negedge clock) begin
        if (estado != prev_st && (estado == 4'd5 || estado == 4'd6 || estado == 4'd8)) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: entered state %0d, expected no event", estado);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("sb_event", 32'({estado, pontuacao, jogadas, pronto}), 32'(e));
            end
        end
        prev_st <= estado;
    end

    task automatic wait_state(input logic [3:0] s, input string name);
        int n = 0;
        while (estado !== s && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(estado), 32'(s));
    endtask

    task automatic wait_led(input logic [6:0] pat, input string name);
        int n = 0;
        while (!(estado == 4'd3 && jogadas == pat) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(jogadas), 32'(pat));
    endtask

    task automatic enter_round(input int t);
        logic [6:0] exp;
        wait_state(4'd3, "varre_entry");
        exp = 7'b1 | (7'b1 << t);
        check("varre_entry_leds", 32'(jogadas), 32'(exp));
    endtask

    task automatic expect_result(input logic [3:0] st, input logic [2:0] pts);
        sb.push_back({st, pts, (st == 4'd5) ? 7'h7F : 7'h00, 1'b0});
    endtask

    task automatic expect_fim(input logic [2:0] pts);
        sb.push_back({4'd8, pts, 7'h00, 1'b1});
    endtask

    task automatic press(input logic [6:0] mask, input logic [3:0] st, input logic [2:0] pts);
        expect_result(st, pts);
        botoes = mask;
        @(negedge clock);
        botoes = '0;
    endtask

    task automatic start_game(input logic d);
        jogar = 1'b1;
        dificuldade = d;
        @(negedge clock);
        jogar = 1'b0;
        check("start_prepara", 32'(estado), 32'd1);
        check("start_pronto", 32'(pronto), 32'd0);
        @(negedge clock);
        check("start_sorteia", 32'(estado), 32'd2);
        check("start_score", 32'(pontuacao), 32'd0);
        @(negedge clock);
        check("start_varre", 32'(estado), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; jogar = 1'b0; dificuldade = 1'b0; botoes = '0;
        repeat (2) @(negedge clock);
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_jogadas", 32'(jogadas), 32'd0);
        check("rst_score", 32'(pontuacao), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // ---- Game 1, hard ----
        start_game(1'b1);
        // R1 t6: press on the terminal cycle of pointer 6 (pre-step value counts)
        enter_round(6);
        repeat (13) @(negedge clock);
        check("step_edge_leds", 32'(jogadas), 32'h40);
        press(7'h01, 4'd5, 3'd1);
        wait_state(4'd5, "r1_acerto");
        n = 0;
        while (estado == 4'd5 && jogadas == 7'h7F && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("feedback_len", 32'(n), 32'd3);
        check("after_feedback", 32'(estado), 32'd7);
        // R2 t4: pointer 3 is a miss in hard mode
        enter_round(4);
        wait_led(7'b0011000, "r2_ptr3");
        press(7'h10, 4'd6, 3'd1);
        // R3 t2: no press -> timeout after 14 steps = 28 cycles
        enter_round(2);
        expect_result(4'd6, 3'd1);
        n = 0;
        while (estado == 4'd3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd28);
        check("timeout_erro", 32'(estado), 32'd6);
        // R4 t2: botoes[2] held from ERRO into VARRE must not count
        botoes = 7'b0000100;
        enter_round(2);
        repeat (6) @(negedge clock);
        check("held_no_eval", 32'(estado), 32'd3);
        botoes = '0;
        wait_led(7'b0000100, "r4_ptr2");
        press(7'b0100001, 4'd5, 3'd2);
        // R5 t3: jogar during VARRE is ignored
        enter_round(3);
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        check("jogar_in_varre", 32'(estado), 32'd3);
        wait_led(7'b0001000, "r5_ptr3");
        press(7'h02, 4'd5, 3'd3);
        expect_fim(3'd3);
        wait_state(4'd8, "g1_fim");
        repeat (4) @(negedge clock);
        check("fim_score_held", 32'(pontuacao), 32'd3);
        check("fim_pronto", 32'(pronto), 32'd1);

        // ---- Game 2, easy ----
        start_game(1'b0);
        enter_round(0);                                 // R6 t0
        wait_led(7'b0000011, "r6_ptr1");
        press(7'h08, 4'd5, 3'd1);
        enter_round(6);                                 // R7 t6, pointer 0: no wrap
        press(7'h04, 4'd6, 3'd1);
        enter_round(6);                                 // R8 t6: press on final wrap
        repeat (55) @(negedge clock);
        check("final_wrap_leds", 32'(jogadas), 32'h40);
        press(7'h01, 4'd5, 3'd2);
        enter_round(3);                                 // R9 t3, pointer 5: miss
        wait_led(7'b0101000, "r9_ptr5");
        press(7'h20, 4'd6, 3'd2);
        enter_round(5);                                 // R10 t5, pointer 6: hit
        wait_led(7'b1100000, "r10_ptr6");
        press(7'h40, 4'd5, 3'd3);
        expect_fim(3'd3);
        wait_state(4'd8, "g2_fim");

        // ---- Game 3, easy, all hits ----
        start_game(1'b0);
        enter_round(4);                                 // R11 t4, pointer 3
        wait_led(7'b0011000, "r11_ptr3");
        press(7'h01, 4'd5, 3'd1);
        enter_round(6);                                 // R12 t6
        wait_led(7'b1000000, "r12_ptr6");
        press(7'h02, 4'd5, 3'd2);
        enter_round(3);                                 // R13 t3
        wait_led(7'b0001000, "r13_ptr3");
        press(7'h04, 4'd5, 3'd3);
        enter_round(4);                                 // R14 t4, pointer 5
        wait_led(7'b0110000, "r14_ptr5");
        press(7'h08, 4'd5, 3'd4);
        enter_round(0);                                 // R15 t0, pointer 1
        wait_led(7'b0000011, "r15_ptr1");
        press(7'h10, 4'd5, 3'd5);
        expect_fim(3'd5);
        wait_state(4'd8, "g3_fim");
        check("g3_score", 32'(pontuacao), 32'd5);
        check("g3_pronto", 32'(pronto), 32'd1);

        // ---- Game 4, hard: reset during ACERTO ----
        start_game(1'b1);
        enter_round(1);                                 // R16 t1
        wait_led(7'b0000010, "r16_ptr1");
        press(7'h01, 4'd5, 3'd1);
        wait_state(4'd5, "r16_acerto");
        #2 reset = 1'b1;
        #1;
        check("async_rst_estado", 32'(estado), 32'd0);
        check("async_rst_jogadas", 32'(jogadas), 32'd0);
        check("async_rst_score", 32'(pontuacao), 32'd0);
        check("async_rst_pronto", 32'(pronto), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // ---- Game 5: LFSR reseeded, round-1 target is 6 again ----
        start_game(1'b1);
        enter_round(6);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
